// File: rtl/cpu_debug_loader_if.sv
// Bus between the debug loader, the host byte streams and the CPU debug port.
// Byte streams: a byte moves on a posedge where valid && ready; the source holds data stable while valid && !ready.
interface cpu_debug_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] addr;
  logic [31:0] din;
  logic        we_im;
  logic        we_dm;
  logic [31:0] dout_im;
  logic [31:0] dout_dm;
  logic [31:0] dout_rf;
  logic        debug;

  modport master (
    input  rx_data, rx_valid, tx_ready, dout_im, dout_dm, dout_rf,
    output rx_ready, tx_data, tx_valid, addr, din, we_im, we_dm, debug
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dout_im, dout_dm, dout_rf,
    input  rx_ready, tx_data, tx_valid, addr, din, we_im, we_dm, debug
  );
endinterface

// File: rtl/cpu_debug_loader.sv
// Byte-serial debug initiator: decodes host commands into CPU debug-port writes/reads
// and streams the responses back.
module cpu_debug_loader (
  input  logic               clk,
  input  logic               rstn,
  cpu_debug_loader_if.master bus,
  output logic [2:0]         state_o
);
  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] ERR_BYTE = 8'hEE;
  localparam logic [7:0] OP_WR_IM = 8'h01;
  localparam logic [7:0] OP_WR_DM = 8'h02;
  localparam logic [7:0] OP_RD_IM = 8'h11;
  localparam logic [7:0] OP_RD_DM = 8'h12;
  localparam logic [7:0] OP_RD_RF = 8'h13;
  localparam logic [7:0] OP_DBG   = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WRITE, S_READ, S_DBG, S_ERR, S_RESP
  } state_t;

  state_t      state_q;
  logic [7:0]  op_q;
  logic [1:0]  cnt_q;
  logic [2:0]  left_q;
  logic [31:0] resp_q;
  logic [31:0] addr_q;
  logic [31:0] din_q;
  logic        we_im_q;
  logic        we_dm_q;
  logic        debug_q;
  logic        rx_ready_q;
  logic        tx_valid_q;

  logic        rx_fire;
  logic        tx_fire;
  logic        is_write;
  logic [31:0] rd_data;

  assign rx_fire  = bus.rx_valid && rx_ready_q;
  assign tx_fire  = tx_valid_q && bus.tx_ready;
  assign is_write = (op_q == OP_WR_IM) || (op_q == OP_WR_DM);

  always_comb begin
    rd_data = bus.dout_rf;
    case (op_q)
      OP_RD_IM: rd_data = bus.dout_im;
      OP_RD_DM: rd_data = bus.dout_dm;
      default:  ;
    endcase
  end

  // rx_ready_q is set alongside every transition so it always reflects the state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      left_q     <= '0;
      resp_q     <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      we_im_q    <= 1'b0;
      we_dm_q    <= 1'b0;
      debug_q    <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            op_q <= bus.rx_data;
            case (bus.rx_data)
              OP_WR_IM, OP_WR_DM, OP_RD_IM, OP_RD_DM, OP_RD_RF: state_q <= S_ADDR;
              OP_DBG: state_q <= S_DBG;
              default: begin
                state_q    <= S_ERR;
                rx_ready_q <= 1'b0;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr_q[{cnt_q, 3'b000} +: 8] <= bus.rx_data;
            if (cnt_q == 2'd3) begin
              cnt_q <= 2'd0;
              if (is_write) begin
                state_q <= S_DATA;
              end else begin
                state_q    <= S_READ;
                rx_ready_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            din_q[{cnt_q, 3'b000} +: 8] <= bus.rx_data;
            if (cnt_q == 2'd3) begin
              cnt_q      <= 2'd0;
              state_q    <= S_WRITE;
              rx_ready_q <= 1'b0;
              we_im_q    <= (op_q == OP_WR_IM);
              we_dm_q    <= (op_q == OP_WR_DM);
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        S_WRITE: begin
          we_im_q    <= 1'b0;
          we_dm_q    <= 1'b0;
          resp_q     <= {24'd0, ACK_BYTE};
          left_q     <= 3'd1;
          tx_valid_q <= 1'b1;
          state_q    <= S_RESP;
        end
        S_READ: begin
          resp_q     <= rd_data;
          left_q     <= 3'd4;
          tx_valid_q <= 1'b1;
          state_q    <= S_RESP;
        end
        S_DBG: begin
          if (rx_fire) begin
            debug_q    <= bus.rx_data[0];
            resp_q     <= {24'd0, ACK_BYTE};
            left_q     <= 3'd1;
            tx_valid_q <= 1'b1;
            rx_ready_q <= 1'b0;
            state_q    <= S_RESP;
          end
        end
        S_ERR: begin
          resp_q     <= {24'd0, ERR_BYTE};
          left_q     <= 3'd1;
          tx_valid_q <= 1'b1;
          state_q    <= S_RESP;
        end
        S_RESP: begin
          if (tx_fire) begin
            if (left_q == 3'd1) begin
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              resp_q <= resp_q >> 8;
              left_q <= left_q - 3'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.tx_data  = resp_q[7:0];
  assign bus.tx_valid = tx_valid_q;
  assign bus.addr     = addr_q;
  assign bus.din      = din_q;
  assign bus.we_im    = we_im_q;
  assign bus.we_dm    = we_dm_q;
  assign bus.debug    = debug_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_cpu_debug_loader.sv
// Bench for cpu_debug_loader: directed command table, backpressure and reset-abort
// sequences, then random commands scored against a memory-level model.
module tb_cpu_debug_loader;
  logic       clk;
  logic       rstn;
  logic [2:0] state_o;

  cpu_debug_loader_if bus();

  cpu_debug_loader dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus.master),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- counters and scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [64:0] exp_wr_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- CPU side: memories answering the debug port ----------------
  function automatic logic [31:0] pat_im(input int i);
    return 32'h1000_0000 + 32'(i) * 32'd3;
  endfunction
  function automatic logic [31:0] pat_dm(input int i);
    return (i == 7) ? 32'hDEAD_BEEF : (32'h2000_0000 ^ (32'(i) << 4));
  endfunction
  function automatic logic [31:0] pat_rf(input int i);
    return (i == 3) ? 32'h0000_0001 : (32'h3000_0000 + 32'(i));
  endfunction

  logic [31:0] im_arr [1024];
  logic [31:0] dm_arr [1024];
  logic        mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) begin
        im_arr[i] <= pat_im(i);
        dm_arr[i] <= pat_dm(i);
      end
      mem_init <= 1'b1;
    end else begin
      if (bus.we_im) im_arr[bus.addr[9:0]] <= bus.din;
      if (bus.we_dm) dm_arr[bus.addr[9:0]] <= bus.din;
    end
  end

  always_comb bus.dout_im = im_arr[bus.addr[9:0]];
  always_comb bus.dout_dm = dm_arr[bus.addr[9:0]];
  always_comb bus.dout_rf = pat_rf(int'(bus.addr[4:0]));

  // ---------------- response sink ----------------
  logic tx_hold = 1'b0;
  always @(posedge clk) begin
    #2;
    bus.tx_ready = tx_hold ? 1'b0 : ($urandom_range(0, 99) < 75);
  end

  // ---------------- monitor ----------------
  int         ncyc = 0;
  int         first_txv_neg = -100;
  int         wr_neg = -100;
  logic       prev_txv = 1'b0;
  logic       stall_q = 1'b0;
  logic [7:0] hold_data = '0;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (!rstn) begin
      prev_txv <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      if (bus.tx_valid && !prev_txv) first_txv_neg <= ncyc + 1;
      prev_txv <= bus.tx_valid;
      if (stall_q) begin
        chk("tx_stall_valid", 64'(bus.tx_valid), 64'd1);
        chk("tx_stall_data", 64'(bus.tx_data), 64'(hold_data));
      end
      stall_q   <= bus.tx_valid && !bus.tx_ready;
      hold_data <= bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected got=%0h exp=none", bus.tx_data);
        end else begin
          chk("tx_byte", 64'(bus.tx_data), 64'(exp_q.pop_front()));
        end
      end
      if (bus.we_im || bus.we_dm) begin
        wr_neg <= ncyc + 1;
        chk("we_exclusive", 64'(bus.we_im && bus.we_dm), 64'd0);
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected got=strobe addr=%0h exp=none", bus.addr);
        end else begin
          logic [64:0] e;
          e = exp_wr_q.pop_front();
          chk("wr_is_im", 64'(bus.we_im), 64'(e[64]));
          chk("wr_addr", 64'(bus.addr), 64'(e[63:32]));
          chk("wr_din", 64'(bus.din), 64'(e[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int acc_neg = 0;
  logic rand_gap = 1'b0;

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (rand_gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL rx_accept_timeout got=rx_ready_low exp=accept byte=%0h", b);
    end
    acc_neg = ncyc;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    send_byte(op);
    if (op inside {8'h01, 8'h02, 8'h11, 8'h12, 8'h13})
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
    if (op inside {8'h01, 8'h02})
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    if (op == 8'h20) send_byte(d[7:0]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.tx_valid) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d_pending exp=0", exp_q.size());
      exp_q.delete();
    end
    chk("wr_pending", 64'(exp_wr_q.size()), 64'd0);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_im [1024];
  logic [31:0] model_dm [1024];
  logic        model_dbg  = 1'b0;
  logic [31:0] model_addr = '0;

  task automatic model_track(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    if (op inside {8'h01, 8'h02, 8'h11, 8'h12, 8'h13}) model_addr = a;
    if (op == 8'h01) model_im[a[9:0]] = d;
    if (op == 8'h02) model_dm[a[9:0]] = d;
    if (op == 8'h20) model_dbg = d[0];
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic model_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    case (op)
      8'h01, 8'h02: begin
        exp_wr_q.push_back({op == 8'h01, a, d});
        exp_q.push_back(8'hA5);
      end
      8'h11: push_word(model_im[a[9:0]]);
      8'h12: push_word(model_dm[a[9:0]]);
      8'h13: push_word(pat_rf(int'(a[4:0])));
      8'h20: exp_q.push_back(8'hA5);
      default: exp_q.push_back(8'hEE);
    endcase
    model_track(op, a, d);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_word;
    int          exp_n;
    logic        exp_dbg;
    logic [31:0] exp_addr;
    int          exp_lat;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    vec_t v;
    int   last_acc;
    logic [7:0] op;
    logic [31:0] a;
    logic [31:0] d;

    vecs[0] = '{8'h01, 32'h4, 32'h1234_5678, 32'hA5,        1, 1'b0, 32'h4, 2};
    vecs[1] = '{8'h12, 32'h7, 32'h0,         32'hDEAD_BEEF, 4, 1'b0, 32'h7, 2};
    vecs[2] = '{8'h55, 32'h0, 32'h0,         32'hEE,        1, 1'b0, 32'h7, 2};
    vecs[3] = '{8'h13, 32'h3, 32'h0,         32'h0000_0001, 4, 1'b0, 32'h3, 2};
    vecs[4] = '{8'h20, 32'h0, 32'h1,         32'hA5,        1, 1'b1, 32'h3, 1};
    vecs[5] = '{8'h20, 32'h0, 32'h0,         32'hA5,        1, 1'b0, 32'h3, 1};
    vecs[6] = '{8'h02, 32'h9, 32'hCAFE_F00D, 32'hA5,        1, 1'b0, 32'h9, 2};
    vecs[7] = '{8'h11, 32'h4, 32'h0,         32'h1234_5678, 4, 1'b0, 32'h4, 2};
    vecs[8] = '{8'h12, 32'h9, 32'h0,         32'hCAFE_F00D, 4, 1'b0, 32'h9, 2};
    vecs[9] = '{8'h20, 32'h0, 32'h3,         32'hA5,        1, 1'b1, 32'h9, 1};

    for (int i = 0; i < 1024; i++) begin
      model_im[i] = pat_im(i);
      model_dm[i] = pat_dm(i);
    end

    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("rst_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
    chk("rst_addr", 64'(bus.addr), 64'd0);
    chk("rst_din", 64'(bus.din), 64'd0);
    chk("rst_we", 64'({bus.we_im, bus.we_dm}), 64'd0);
    chk("rst_debug", 64'(bus.debug), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_rx_ready", 64'(bus.rx_ready), 64'd1);

    for (int r = 0; r < NV; r++) begin
      v = vecs[r];
      for (int k = 0; k < v.exp_n; k++) exp_q.push_back(v.exp_word[8*k +: 8]);
      if (v.op inside {8'h01, 8'h02}) exp_wr_q.push_back({v.op == 8'h01, v.a, v.d});
      model_track(v.op, v.a, v.d);
      send_cmd(v.op, v.a, v.d);
      last_acc = acc_neg;
      wait_drain();
      chk($sformatf("v%0d_debug", r), 64'(bus.debug), 64'(v.exp_dbg));
      chk($sformatf("v%0d_addr", r), 64'(bus.addr), 64'(v.exp_addr));
      chk($sformatf("v%0d_tx_latency", r), 64'(first_txv_neg - last_acc), 64'(v.exp_lat));
      if (v.op inside {8'h01, 8'h02})
        chk($sformatf("v%0d_we_latency", r), 64'(wr_neg - last_acc), 64'd1);
    end

    // Backpressure: response held for 10 cycles with the sink stalled.
    tx_hold = 1'b1;
    push_word(32'hDEAD_BEEF);
    send_cmd(8'h12, 32'h7, 32'h0);
    for (int n = 0; n < 50 && !bus.tx_valid; n++) begin
      @(negedge clk);
      #1;
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      #1;
      chk("bp_tx_valid", 64'(bus.tx_valid), 64'd1);
      chk("bp_tx_data", 64'(bus.tx_data), 64'hEF);
      chk("bp_rx_ready", 64'(bus.rx_ready), 64'd0);
    end
    tx_hold = 1'b0;
    wait_drain();

    // Reset in the middle of a DM write (6 bytes in) with debug set.
    chk("pre_rst_debug", 64'(bus.debug), 64'd1);
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'h05 >> (8 * i));
    send_byte(8'h44);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("abort_tx_valid", 64'(bus.tx_valid), 64'd0);
    chk("abort_tx_data", 64'(bus.tx_data), 64'd0);
    chk("abort_addr", 64'(bus.addr), 64'd0);
    chk("abort_din", 64'(bus.din), 64'd0);
    chk("abort_we", 64'({bus.we_im, bus.we_dm}), 64'd0);
    chk("abort_debug", 64'(bus.debug), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
    model_dbg  = 1'b0;
    model_addr = '0;
    @(posedge clk);
    #1;
    chk("abort_rel_rx_ready", 64'(bus.rx_ready), 64'd1);
    model_cmd(8'h02, 32'h5, 32'h1122_3344);
    send_cmd(8'h02, 32'h5, 32'h1122_3344);
    wait_drain();
    model_cmd(8'h12, 32'h5, 32'h0);
    send_cmd(8'h12, 32'h5, 32'h0);
    wait_drain();
    chk("abort_after_addr", 64'(bus.addr), 64'(model_addr));

    // Random commands with gaps on both streams.
    rand_gap = 1'b1;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 6))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h11;
        3: op = 8'h12;
        4: op = 8'h13;
        5: op = 8'h20;
        default: begin
          op = 8'($urandom_range(0, 255));
          while (op inside {8'h01, 8'h02, 8'h11, 8'h12, 8'h13, 8'h20})
            op = 8'($urandom_range(0, 255));
        end
      endcase
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
      d = $urandom;
      model_cmd(op, a, d);
      send_cmd(op, a, d);
      wait_drain();
      chk($sformatf("r%0d_debug", t), 64'(bus.debug), 64'(model_dbg));
      chk($sformatf("r%0d_addr", t), 64'(bus.addr), 64'(model_addr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
